rob_multi_cdb: RTL and testbench

Parametrised reorder buffer for the out-of-order core. It allocates tags to decoded instructions in program order and captures results from CDB_N broadcast channels. It serves operand lookups with same-cycle CDB bypass and commits one instruction per cycle to the register file. It also raises a pipeline flush when a mispredicted branch reaches the head of the buffer.

---
 rtl/rob_multi_cdb.sv | 157 +++++++++++++++
 tb/tb_rob_multi_cdb.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multi_cdb.sv
// Reorder buffer: in-order tag allocation, multi-channel CDB capture, operand
// lookup with same-cycle bypass, single in-order commit and mispredict flush.
module rob_multi_cdb #(
  parameter int DEPTH = 15,
  parameter int TAG_W = 4,
  parameter int XLEN  = 32,
  parameter int REG_W = 5,
  parameter int CDB_N = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_valid,
  input  logic [REG_W-1:0]        alloc_rd,
  output logic                    alloc_ready,
  output logic [TAG_W-1:0]        alloc_tag,
  input  logic [TAG_W-1:0]        qj_in,
  input  logic [TAG_W-1:0]        qk_in,
  output logic                    vj_ready,
  output logic                    vk_ready,
  output logic [XLEN-1:0]         vj_out,
  output logic [XLEN-1:0]         vk_out,
  input  logic [CDB_N-1:0]        cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]  cdb_tag,
  input  logic [CDB_N*XLEN-1:0]   cdb_data,
  input  logic [CDB_N-1:0]        cdb_mispredict,
  input  logic [CDB_N*XLEN-1:0]   cdb_target,
  output logic                    commit_valid,
  output logic [TAG_W-1:0]        commit_tag,
  output logic [REG_W-1:0]        commit_rd,
  output logic [XLEN-1:0]         commit_data,
  output logic                    flush_out,
  output logic [XLEN-1:0]         flush_pc,
  output logic [TAG_W:0]          count_out
);

  logic [TAG_W-1:0] head, tail, head_nxt, tail_nxt;
  logic [TAG_W:0]   count, count_nxt;
  logic [DEPTH:1]   busy, ready, misp;
  logic [REG_W-1:0] rd_q   [1:DEPTH];
  logic [XLEN-1:0]  data_q [1:DEPTH];
  logic [XLEN-1:0]  tgt_q  [1:DEPTH];
  logic             alloc_fire, do_commit;
  logic [TAG_W-1:0] bc_tag [CDB_N];
  logic [CDB_N-1:0] bc_hit;

  function automatic logic tag_ok(input logic [TAG_W-1:0] t);
    return (t != '0) && ({1'b0, t} <= (TAG_W+1)'(DEPTH));
  endfunction

  // Bypass takes priority over storage; lowest matching channel wins.
  function automatic logic [XLEN:0] lookup(input logic [TAG_W-1:0] q);
    logic            hit;
    logic [XLEN-1:0] val;
    hit = 1'b0;
    val = '0;
    if (q != '0) begin
      if (tag_ok(q) && ready[q]) begin
        hit = 1'b1;
        val = data_q[q];
      end
      for (int unsigned i = CDB_N; i > 0; i--) begin
        if (cdb_valid[i-1] && cdb_tag[(i-1)*TAG_W +: TAG_W] == q) begin
          hit = 1'b1;
          val = cdb_data[(i-1)*XLEN +: XLEN];
        end
      end
    end
    return {hit, val};
  endfunction

  assign {vj_ready, vj_out} = lookup(qj_in);
  assign {vk_ready, vk_out} = lookup(qk_in);

  assign alloc_ready = (count < (TAG_W+1)'(DEPTH)) && !flush_out;
  assign alloc_tag   = alloc_ready ? tail : '0;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign do_commit   = (count != '0) && ready[head];
  assign count_out   = count;
  assign tail_nxt    = (tail == TAG_W'(DEPTH)) ? TAG_W'(1) : tail + TAG_W'(1);
  assign head_nxt    = (head == TAG_W'(DEPTH)) ? TAG_W'(1) : head + TAG_W'(1);

  always_comb begin
    for (int unsigned i = 0; i < CDB_N; i++) begin
      bc_tag[i] = cdb_tag[i*TAG_W +: TAG_W];
      bc_hit[i] = cdb_valid[i] && tag_ok(bc_tag[i]) && busy[bc_tag[i]];
    end
  end

  always_comb begin
    count_nxt = count;
    if (alloc_fire && !do_commit)
      count_nxt = count + (TAG_W+1)'(1);
    else if (!alloc_fire && do_commit)
      count_nxt = count - (TAG_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= TAG_W'(1);
      tail         <= TAG_W'(1);
      count        <= '0;
      busy         <= '0;
      ready        <= '0;
      misp         <= '0;
      commit_valid <= 1'b0;
      commit_tag   <= '0;
      commit_rd    <= '0;
      commit_data  <= '0;
      flush_out    <= 1'b0;
      flush_pc     <= '0;
    end else begin
      commit_valid <= 1'b0;
      flush_out    <= 1'b0;
      if (do_commit) begin
        commit_valid <= 1'b1;
        commit_tag   <= head;
        commit_rd    <= rd_q[head];
        commit_data  <= data_q[head];
      end
      if (do_commit && misp[head]) begin
        // Mispredict at head: this update both commits it and empties the buffer.
        flush_out <= 1'b1;
        flush_pc  <= tgt_q[head];
        head      <= TAG_W'(1);
        tail      <= TAG_W'(1);
        count     <= '0;
        busy      <= '0;
        ready     <= '0;
        misp      <= '0;
      end else begin
        // Iterate high to low so the lowest channel's write lands last.
        for (int unsigned i = CDB_N; i > 0; i--) begin
          if (bc_hit[i-1]) begin
            ready[bc_tag[i-1]]  <= 1'b1;
            misp[bc_tag[i-1]]   <= cdb_mispredict[i-1];
            data_q[bc_tag[i-1]] <= cdb_data[(i-1)*XLEN +: XLEN];
            tgt_q[bc_tag[i-1]]  <= cdb_target[(i-1)*XLEN +: XLEN];
          end
        end
        if (alloc_fire) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          misp[tail]  <= 1'b0;
          rd_q[tail]  <= alloc_rd;
          tail        <= tail_nxt;
        end
        if (do_commit) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= head_nxt;
        end
        count <= count_nxt;
      end
    end
  end

endmodule

// File: tb/tb_rob_multi_cdb.sv
// Randomized scoreboard bench for rob_multi_cdb against a queue-based program-order model.
module tb_rob_multi_cdb;
  localparam int DEPTH = 15;
  localparam int TAG_W = 4;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int CDB_N = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   alloc_valid;
  logic [REG_W-1:0]       alloc_rd;
  logic                   alloc_ready;
  logic [TAG_W-1:0]       alloc_tag;
  logic [TAG_W-1:0]       qj_in, qk_in;
  logic                   vj_ready, vk_ready;
  logic [XLEN-1:0]        vj_out, vk_out;
  logic [CDB_N-1:0]       cdb_valid;
  logic [CDB_N*TAG_W-1:0] cdb_tag;
  logic [CDB_N*XLEN-1:0]  cdb_data;
  logic [CDB_N-1:0]       cdb_mispredict;
  logic [CDB_N*XLEN-1:0]  cdb_target;
  logic                   commit_valid;
  logic [TAG_W-1:0]       commit_tag;
  logic [REG_W-1:0]       commit_rd;
  logic [XLEN-1:0]        commit_data;
  logic                   flush_out;
  logic [XLEN-1:0]        flush_pc;
  logic [TAG_W:0]         count_out;

  rob_multi_cdb #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .REG_W(REG_W), .CDB_N(CDB_N)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .qj_in(qj_in), .qk_in(qk_in), .vj_ready(vj_ready), .vk_ready(vk_ready),
    .vj_out(vj_out), .vk_out(vk_out),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
    .commit_data(commit_data), .flush_out(flush_out), .flush_pc(flush_pc),
    .count_out(count_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    int          rd;
    bit          rdy;
    logic [31:0] data;
    bit          misp;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    int          tag;
    int          rd;
    logic [31:0] data;
    bit          flush;
    logic [31:0] pc;
  } cmt_t;

  ent_t rob[$];
  cmt_t exp_q[$];
  int   ntag = 1;
  bit   mflush = 0;
  bit   chk_en = 0;
  bit   started = 0;
  int   vectors = 0;
  int   errs = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
    vectors++;
    if (act != req) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit exp_ready();
    return (rob.size() < DEPTH) && !mflush;
  endfunction

  function automatic void mlook(input int q, output bit r, output logic [31:0] v);
    r = 0;
    v = '0;
    if (q == 0) return;
    for (int i = 0; i < CDB_N; i++)
      if (cdb_valid[i] && int'(cdb_tag[i*TAG_W +: TAG_W]) == q) begin
        r = 1;
        v = cdb_data[i*XLEN +: XLEN];
        return;
      end
    foreach (rob[n])
      if (rob[n].tag == q && rob[n].rdy) begin
        r = 1;
        v = rob[n].data;
      end
  endfunction

  function automatic void model_edge(input bit fire);
    bit   claimed [0:(1<<TAG_W)-1];
    cmt_t c;
    ent_t e;
    int   t;
    if (rst) begin
      rob.delete();
      ntag = 1;
      mflush = 0;
      return;
    end
    mflush = 0;
    if (rob.size() > 0 && rob[0].rdy) begin
      c = '{rob[0].tag, rob[0].rd, rob[0].data, rob[0].misp, rob[0].tgt};
      exp_q.push_back(c);
      void'(rob.pop_front());
      if (c.flush) begin
        rob.delete();
        ntag = 1;
        mflush = 1;
        return;
      end
    end
    foreach (claimed[i]) claimed[i] = 0;
    for (int i = 0; i < CDB_N; i++) begin
      t = int'(cdb_tag[i*TAG_W +: TAG_W]);
      if (cdb_valid[i] && t != 0 && !claimed[t]) begin
        claimed[t] = 1;
        foreach (rob[n])
          if (rob[n].tag == t) begin
            rob[n].rdy  = 1;
            rob[n].data = cdb_data[i*XLEN +: XLEN];
            rob[n].misp = cdb_mispredict[i];
            rob[n].tgt  = cdb_target[i*XLEN +: XLEN];
          end
      end
    end
    if (fire) begin
      e = '{ntag, int'(alloc_rd), 0, '0, 0, '0};
      rob.push_back(e);
      ntag = (ntag == DEPTH) ? 1 : ntag + 1;
    end
  endfunction

  // Called at a falling edge with inputs already driven.
  task automatic step();
    bit          jr, kr, fire;
    logic [31:0] jv, kv;
    #1;
    if (chk_en) begin
      chk("alloc_ready", alloc_ready, exp_ready());
      chk("alloc_tag", alloc_tag, exp_ready() ? ntag : 0);
      chk("count_out", count_out, rob.size());
      mlook(int'(qj_in), jr, jv);
      mlook(int'(qk_in), kr, kv);
      chk("vj_ready", vj_ready, jr);
      chk("vk_ready", vk_ready, kr);
      if (jr || qj_in == '0) chk("vj_out", vj_out, jv);
      if (kr || qk_in == '0) chk("vk_out", vk_out, kv);
    end
    fire = alloc_valid && exp_ready() && !rst;
    @(posedge clk);
    model_edge(fire);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0;
    alloc_valid = 0;
    alloc_rd = '0;
    qj_in = '0;
    qk_in = '0;
    cdb_valid = '0;
    cdb_tag = '0;
    cdb_data = '0;
    cdb_mispredict = '0;
    cdb_target = '0;
  endtask

  task automatic bc(input int ch, input int tag, input logic [31:0] d, input bit m, input logic [31:0] tg);
    cdb_valid[ch] = 1'b1;
    cdb_tag[ch*TAG_W +: TAG_W] = TAG_W'(tag);
    cdb_data[ch*XLEN +: XLEN] = d;
    cdb_mispredict[ch] = m;
    cdb_target[ch*XLEN +: XLEN] = tg;
  endtask

  function automatic logic [TAG_W-1:0] pick_q();
    case ($urandom_range(0, 3))
      0: return '0;
      1: return cdb_tag[TAG_W-1:0];
      2: return TAG_W'($urandom);
      default: return (rob.size() > 0) ? TAG_W'(rob[$urandom_range(0, rob.size()-1)].tag) : TAG_W'($urandom);
    endcase
  endfunction

  task automatic rnd_inputs(input bit fill);
    int pick;
    alloc_valid = ($urandom_range(0, 9) < (fill ? 9 : 3));
    alloc_rd = REG_W'($urandom);
    for (int i = 0; i < CDB_N; i++) begin
      cdb_valid[i] = ($urandom_range(0, 9) < (fill ? 1 : 8));
      if (rob.size() > 0 && $urandom_range(0, 7) != 0)
        pick = rob[$urandom_range(0, rob.size()-1)].tag;
      else
        pick = int'($urandom_range(0, (1<<TAG_W)-1));
      if (i > 0 && $urandom_range(0, 3) == 0) pick = int'(cdb_tag[TAG_W-1:0]);
      cdb_tag[i*TAG_W +: TAG_W] = TAG_W'(pick);
      cdb_data[i*XLEN +: XLEN] = $urandom;
      cdb_mispredict[i] = ($urandom_range(0, 39) == 0);
      cdb_target[i*XLEN +: XLEN] = $urandom;
    end
    qj_in = pick_q();
    qk_in = pick_q();
    rst = ($urandom_range(0, 399) == 0);
  endtask

  // Monitor: pops one expected commit per observed commit pulse.
  initial begin
    cmt_t e;
    wait (started);
    forever begin
      @(posedge clk);
      #1;
      if (commit_valid) begin
        if (exp_q.size() == 0) chk("unexpected_commit", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("commit_tag", commit_tag, e.tag);
          chk("commit_rd", commit_rd, e.rd);
          chk("commit_data", commit_data, e.data);
          chk("flush_out", flush_out, e.flush);
          if (e.flush) chk("flush_pc", flush_pc, e.pc);
        end
      end else if (flush_out) chk("flush_without_commit", 1, 0);
      if (exp_q.size() != 0) begin
        chk("missing_commit", 0, exp_q.size());
        exp_q.delete();
      end
    end
  end

  initial begin
    idle();
    @(negedge clk);
    rst = 1;
    step();
    step();
    rst = 0;
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_commit_tag", commit_tag, 0);
    chk("rst_commit_rd", commit_rd, 0);
    chk("rst_commit_data", commit_data, 0);
    chk("rst_flush_out", flush_out, 0);
    chk("rst_flush_pc", flush_pc, 0);
    chk_en = 1;
    started = 1;

    // Three allocations, out-of-order completion, dual-channel bypass lookups.
    for (int i = 1; i <= 3; i++) begin
      idle(); alloc_valid = 1; alloc_rd = REG_W'(i); step();
    end
    idle(); bc(0, 2, 32'hAA, 0, '0); qj_in = 4'd2; step();
    idle(); bc(1, 1, 32'h11, 0, '0); qj_in = 4'd1; qk_in = 4'd2; step();
    idle(); bc(0, 3, 32'h1, 0, '0); bc(1, 3, 32'h2, 0, '0); qj_in = 4'd3; step();
    repeat (3) begin idle(); step(); end

    // Mispredict at tag 2 with younger entries queued behind it.
    idle(); rst = 1; step();
    for (int i = 1; i <= 4; i++) begin
      idle(); alloc_valid = 1; alloc_rd = REG_W'(i + 8); step();
    end
    idle(); bc(0, 1, 32'h10, 0, '0); bc(1, 2, 32'h20, 1, 32'h1000); qj_in = 4'd1; qk_in = 4'd2; step();
    idle(); bc(0, 3, 32'h30, 0, '0); bc(1, 4, 32'h40, 0, '0); alloc_valid = 1; step();
    repeat (4) begin idle(); alloc_valid = 1; step(); end

    // Reset with busy entries and a ready head.
    idle(); rst = 1; step();
    for (int i = 0; i < 5; i++) begin
      idle(); alloc_valid = 1; alloc_rd = REG_W'(i); step();
    end
    idle(); bc(0, 1, 32'h5, 0, '0); step();
    idle(); rst = 1; step();
    idle(); step();

    // Alternate fill-heavy and drain-heavy random phases.
    for (int p = 0; p < 10; p++)
      for (int c = 0; c < 150; c++) begin
        rnd_inputs(p % 2 == 0);
        step();
      end
    repeat (20) begin idle(); qj_in = TAG_W'($urandom); step(); end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
